// File: rtl/pool1_max.sv
// rtl/pool1_max.sv - 2x2 stride-2 signed max pooling over a stream of conv-layer-1 rows
// Holds the top row of each pair, emits one registered pooled row per bottom row.
module pool1_max #(
    parameter int W    = 16,
    parameter int COLS = 28,
    parameter int ROWS = 28,
    parameter int RELU = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W*COLS-1:0]     in_row,
    output logic                  out_valid,
    output logic [W*COLS/2-1:0]   out_row,
    output logic [3:0]            out_idx,
    output logic                  frame_done
);

    localparam int          OCOLS    = COLS / 2;
    localparam logic [3:0]  LAST_IDX = 4'(ROWS / 2 - 1);

    typedef enum logic {
        WAIT_A,
        WAIT_B
    } state_t;

    state_t                 state_q, state_d;
    logic [W*COLS-1:0]      top_q, top_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [W*OCOLS-1:0]     out_row_q, out_row_d;
    logic [3:0]             out_idx_q, out_idx_d;
    logic [W*OCOLS-1:0]     pooled;

    // Combinational pool of the held top row against the incoming bottom row
    for (genvar j = 0; j < OCOLS; j++) begin : g_pool
        logic signed [W-1:0] t0, t1, b0, b1, mt, mb, mx;
        assign t0 = top_q[W*(2*j)   +: W];
        assign t1 = top_q[W*(2*j+1) +: W];
        assign b0 = in_row[W*(2*j)   +: W];
        assign b1 = in_row[W*(2*j+1) +: W];
        assign mt = (t0 > t1) ? t0 : t1;
        assign mb = (b0 > b1) ? b0 : b1;
        assign mx = (mt > mb) ? mt : mb;
        assign pooled[W*j +: W] = ((RELU != 0) && (mx < 0)) ? '0 : mx;
    end

    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        cnt_d        = cnt_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_row_d    = out_row_q;
        out_idx_d    = out_idx_q;
        case (state_q)
            WAIT_A: begin
                if (in_valid) begin
                    top_d   = in_row;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (in_valid) begin
                    out_valid_d  = 1'b1;
                    out_row_d    = pooled;
                    out_idx_d    = cnt_q;
                    frame_done_d = (cnt_q == LAST_IDX);
                    cnt_d        = (cnt_q == LAST_IDX) ? 4'd0 : cnt_q + 4'd1;
                    state_d      = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_A;
            top_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            out_row_q    <= out_row_d;
            out_idx_q    <= out_idx_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_idx    = out_idx_q;

endmodule

// File: tb/tb_pool1_max.sv
// tb/tb_pool1_max.sv - scoreboard bench for pool1_max (RELU=1 and RELU=0 instances)
module tb_pool1_max;

    localparam int W    = 16;
    localparam int COLS = 28;
    localparam int ROWS = 28;
    localparam int RW   = W * COLS;
    localparam int OW   = W * COLS / 2;

    typedef struct {
        logic [OW-1:0] row;
        logic [3:0]    idx;
        logic          fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_row;

    logic          out_valid_a, frame_done_a, out_valid_b, frame_done_b;
    logic [OW-1:0] out_row_a, out_row_b;
    logic [3:0]    out_idx_a, out_idx_b;

    exp_t          q_a[$];
    exp_t          q_b[$];
    int            vectors = 0;
    int            errors  = 0;
    int            exp_idx = 0;
    logic [RW-1:0] frame_rows [ROWS];

    pool1_max #(.W(W), .COLS(COLS), .ROWS(ROWS), .RELU(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row),
        .out_valid(out_valid_a), .out_row(out_row_a), .out_idx(out_idx_a),
        .frame_done(frame_done_a)
    );

    pool1_max #(.W(W), .COLS(COLS), .ROWS(ROWS), .RELU(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_row(in_row),
        .out_valid(out_valid_b), .out_row(out_row_b), .out_idx(out_idx_b),
        .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pool_model(input logic [RW-1:0] t, input logic [RW-1:0] b,
                                                 input bit relu);
        logic [OW-1:0] r;
        r = '0;
        for (int j = 0; j < COLS / 2; j++) begin
            logic signed [W-1:0] m;
            logic signed [W-1:0] v [4];
            v[0] = t[W*(2*j) +: W];
            v[1] = t[W*(2*j+1) +: W];
            v[2] = b[W*(2*j) +: W];
            v[3] = b[W*(2*j+1) +: W];
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
            if (relu && m < 0) m = '0;
            r[W*j +: W] = m;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_row(input logic [RW-1:0] r);
        in_valid = 1'b1;
        in_row   = r;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [OW-1:0] ea, input logic [OW-1:0] eb);
        exp_t e;
        e.idx = 4'(exp_idx);
        e.fd  = (exp_idx == ROWS / 2 - 1);
        e.row = ea;
        q_a.push_back(e);
        e.row = eb;
        q_b.push_back(e);
        exp_idx = (exp_idx == ROWS / 2 - 1) ? 0 : exp_idx + 1;
    endtask

    // Expectations are pushed before the bottom row is clocked in
    task automatic send_pair_exp(input logic [RW-1:0] t, input logic [RW-1:0] b, input int gap,
                                 input logic [OW-1:0] ea, input logic [OW-1:0] eb);
        send_row(t);
        idle(gap);
        push_exp(ea, eb);
        send_row(b);
    endtask

    task automatic send_pair(input logic [RW-1:0] t, input logic [RW-1:0] b, input int gap);
        send_pair_exp(t, b, gap, pool_model(t, b, 1'b1), pool_model(t, b, 1'b0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_idx = 0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_a_row"}, out_row_a, '0);
        check({name, "_a_ctl"}, OW'({out_valid_a, frame_done_a, out_idx_a}), '0);
        check({name, "_b_row"}, out_row_b, '0);
        check({name, "_b_ctl"}, OW'({out_valid_b, frame_done_b, out_idx_b}), '0);
    endtask

    always @(negedge clk) begin
        if (out_valid_a) begin
            if (q_a.size() == 0) check("a_unexpected_valid", OW'(1), OW'(0));
            else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_row", out_row_a, e.row);
                check("a_idx", OW'(out_idx_a), OW'(e.idx));
                check("a_frame_done", OW'(frame_done_a), OW'(e.fd));
            end
        end else if (frame_done_a) check("a_stray_frame_done", OW'(1), OW'(0));
    end

    always @(negedge clk) begin
        if (out_valid_b) begin
            if (q_b.size() == 0) check("b_unexpected_valid", OW'(1), OW'(0));
            else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_row", out_row_b, e.row);
                check("b_idx", OW'(out_idx_b), OW'(e.idx));
                check("b_frame_done", OW'(frame_done_b), OW'(e.fd));
            end
        end else if (frame_done_b) check("b_stray_frame_done", OW'(1), OW'(0));
    end

    initial begin
        logic [RW-1:0] t, b;
        logic [OW-1:0] ea, eb;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_row   = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        exp_idx = 0;

        // Ramp rows: pooled pixel j = 100+2j+1
        for (int k = 0; k < COLS; k++) begin
            t[W*k +: W] = W'(k);
            b[W*k +: W] = W'(100 + k);
        end
        for (int j = 0; j < COLS / 2; j++) ea[W*j +: W] = W'(100 + 2 * j + 1);
        send_pair_exp(t, b, 0, ea, ea);
        idle(2);

        // Extremes and all-negative window
        t = '0; b = '0;
        t[W*0 +: W] = 16'h8000; t[W*1 +: W] = 16'h7FFF;
        b[W*0 +: W] = 16'h8000; b[W*1 +: W] = 16'h8000;
        t[W*2 +: W] = -16'sd5;  t[W*3 +: W] = -16'sd3;
        b[W*2 +: W] = -16'sd9;  b[W*3 +: W] = -16'sd1;
        ea = '0; eb = '0;
        ea[W*0 +: W] = 16'h7FFF; ea[W*1 +: W] = 16'h0000;
        eb[W*0 +: W] = 16'h7FFF; eb[W*1 +: W] = 16'hFFFF;
        send_pair_exp(t, b, 2, ea, eb);
        idle(3);
        check("hold_row_a", out_row_a, ea);
        check("hold_row_b", out_row_b, eb);

        // Abort a pair with reset, then a fresh pair starts at idx 0
        for (int k = 0; k < COLS; k++) t[W*k +: W] = 16'h7000;
        send_row(t);
        do_reset();
        for (int k = 0; k < COLS; k++) begin
            t[W*k +: W] = W'(k * 3 - 20);
            b[W*k +: W] = W'(7 - k);
        end
        send_pair(t, b, 1);
        idle(2);

        // Reset and in_valid together: row ignored
        in_valid = 1'b1;
        in_row   = {RW{1'b1}};
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_idx  = 0;
        check_zero("rst_with_valid");

        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++) frame_rows[r][W*k +: W] = W'($urandom);

        // Back-to-back frame, then the same rows with random gaps
        for (int p = 0; p < ROWS / 2; p++) send_pair(frame_rows[2*p], frame_rows[2*p+1], 0);
        for (int p = 0; p < ROWS / 2; p++) begin
            idle($urandom_range(0, 3));
            send_pair(frame_rows[2*p], frame_rows[2*p+1], $urandom_range(0, 4));
        end
        // Second back-to-back frame to confirm wrap
        for (int p = 0; p < ROWS / 2; p++) send_pair(frame_rows[p], frame_rows[ROWS-1-p], 0);
        idle(4);

        check("pending_a", OW'(q_a.size()), '0);
        check("pending_b", OW'(q_b.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
